// File: rtl/barrel_sprite_renderer.sv
// -----------------------------------------------------------------------------
// barrel_sprite_renderer
//
// Purpose:
//   Renders the barrel sprite once per animation frame. On a frame tick it
//   erases the box it drew last time (using the background colour), then
//   draws a SIZE x SIZE barrel at the newly sampled position. Pixels stream
//   to the shared 160x120 VGA adapter, one pixel per granted cycle.
//
// Ports:
//   Clk        in   1  system clock
//   ResetN     in   1  synchronous, active-low reset
//   posX       in   8  barrel top-left X from the motion stage
//   posY       in   7  barrel top-left Y from the motion stage
//   frameTick  in   1  one-cycle pulse at the start of an animation frame
//   gnt        in   1  VGA write grant; a pixel is consumed only when high
//   req        out  1  request to the arbiter (erase or draw pass active)
//   vgaPlot    out  1  write strobe to the VGA adapter
//   vgaXo      out  8  pixel X
//   vgaYo      out  7  pixel Y
//   vgaColour  out  3  pixel colour (0 whenever vgaPlot is low)
//   busy       out  1  renderer is not idle
//   done       out  1  one-cycle pulse when a frame render completes
//
// States:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for a frame tick (or a tick merged while busy)
//   S_ERASE | painting the previously drawn box with BG_COL
//   S_DRAW  | painting the sprite at the newly latched position
//   S_DONE  | one cycle: commit the new position as the drawn one
// -----------------------------------------------------------------------------
module barrel_sprite_renderer #(
    parameter int          SIZE     = 5,
    parameter logic [2:0]  BG_COL   = 3'b000,
    parameter logic [2:0]  RIM_COL  = 3'b110,
    parameter logic [2:0]  BODY_COL = 3'b100,
    parameter int          SCR_W    = 160,
    parameter int          SCR_H    = 120
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic [7:0]  posX,
    input  logic [6:0]  posY,
    input  logic        frameTick,
    input  logic        gnt,
    output logic        req,
    output logic        vgaPlot,
    output logic [7:0]  vgaXo,
    output logic [6:0]  vgaYo,
    output logic [2:0]  vgaColour,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAST   = 3'(SIZE - 1);
    localparam logic [8:0] LIM_X  = 9'(SCR_W);
    localparam logic [7:0] LIM_Y  = 8'(SCR_H);

    state_t      state;
    state_t      state_next;

    logic [2:0]  cx;
    logic [2:0]  cy;
    logic [7:0]  new_x;
    logic [6:0]  new_y;
    logic [7:0]  drawn_x;
    logic [6:0]  drawn_y;
    logic        drawn_valid;
    logic        pending;

    logic        active;
    logic        consume;
    logic        last_pix;
    logic        start;
    logic        same_pos;

    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic [8:0]  sum_x;
    logic [7:0]  sum_y;
    logic        in_bounds;
    logic        edge_x;
    logic        edge_y;
    logic [2:0]  sprite_col;
    logic [2:0]  pix_col;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign active   = (state == S_ERASE) || (state == S_DRAW);
    assign consume  = active && gnt;
    assign last_pix = (cx == LAST) && (cy == LAST);
    assign start    = (state == S_IDLE) && (frameTick || pending);
    // Compared against the live position: it is the value being latched on
    // the same edge, so the decision matches what will be drawn.
    assign same_pos = drawn_valid && (posX == drawn_x) && (posY == drawn_y);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!drawn_valid) begin
                        state_next = S_DRAW;
                    end else if (same_pos) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ERASE;
                    end
                end
            end
            S_ERASE: begin
                if (consume && last_pix) begin
                    state_next = S_DRAW;
                end
            end
            S_DRAW: begin
                if (consume && last_pix) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: raster counters, positions, tick merging
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            cx          <= '0;
            cy          <= '0;
            new_x       <= '0;
            new_y       <= '0;
            drawn_x     <= '0;
            drawn_y     <= '0;
            drawn_valid <= 1'b0;
            pending     <= 1'b0;
        end else begin
            if (start) begin
                new_x   <= posX;
                new_y   <= posY;
                pending <= 1'b0;
            end else if (frameTick && (state != S_IDLE)) begin
                // All ticks arriving during a frame collapse into one rerun;
                // the position is sampled when that rerun starts.
                pending <= 1'b1;
            end

            // Both passes walk the same raster; wrapping to zero at the end
            // of a pass leaves the counters ready for the next pass.
            if (consume) begin
                if (cx == LAST) begin
                    cx <= '0;
                    if (cy == LAST) begin
                        cy <= '0;
                    end else begin
                        cy <= cy + 3'd1;
                    end
                end else begin
                    cx <= cx + 3'd1;
                end
            end

            if (state == S_DONE) begin
                drawn_x     <= new_x;
                drawn_y     <= new_y;
                drawn_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel address and clipping
    // ------------------------------------------------------------------
    always_comb begin
        base_x = new_x;
        base_y = new_y;
        if (state == S_ERASE) begin
            base_x = drawn_x;
            base_y = drawn_y;
        end
    end

    // One extra bit so a sprite hanging off the right/bottom edge clips
    // instead of wrapping to the opposite side of the screen.
    assign sum_x     = {1'b0, base_x} + {6'b0, cx};
    assign sum_y     = {1'b0, base_y} + {5'b0, cy};
    assign in_bounds = (sum_x < LIM_X) && (sum_y < LIM_Y);

    // ------------------------------------------------------------------
    // Sprite colour: transparent corners, rim on the border, body inside
    // ------------------------------------------------------------------
    assign edge_x = (cx == 3'd0) || (cx == LAST);
    assign edge_y = (cy == 3'd0) || (cy == LAST);

    always_comb begin
        sprite_col = BODY_COL;
        if (edge_x && edge_y) begin
            sprite_col = BG_COL;
        end else if (edge_x || edge_y) begin
            sprite_col = RIM_COL;
        end
    end

    assign pix_col = (state == S_ERASE) ? BG_COL : sprite_col;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req       = active;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign vgaPlot   = consume && in_bounds;
    // Coordinates stay valid through a grant stall so the adapter sees a
    // stable address until the pixel is actually taken.
    assign vgaXo     = active ? sum_x[7:0] : 8'd0;
    assign vgaYo     = active ? sum_y[6:0] : 7'd0;
    assign vgaColour = vgaPlot ? pix_col : 3'd0;

endmodule

// File: tb/tb_barrel_sprite_renderer.sv
module tb_barrel_sprite_renderer;

    logic        Clk;
    logic        ResetN;
    logic [7:0]  posX;
    logic [6:0]  posY;
    logic        frameTick;
    logic        gnt;
    logic        req;
    logic        vgaPlot;
    logic [7:0]  vgaXo;
    logic [6:0]  vgaYo;
    logic [2:0]  vgaColour;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    // gnt pattern used by run_frame: 0 = held high, 1 = high on odd cycles
    bit gnt_toggle = 1'b0;

    logic [7:0] px[$];
    logic [6:0] py[$];
    logic [2:0] pc[$];

    // Hand-derived 5x5 sprite in raster order (0=BG, 6=RIM, 4=BODY)
    logic [2:0] spr [25] = '{
        3'd0, 3'd6, 3'd6, 3'd6, 3'd0,
        3'd6, 3'd4, 3'd4, 3'd4, 3'd6,
        3'd6, 3'd4, 3'd4, 3'd4, 3'd6,
        3'd6, 3'd4, 3'd4, 3'd4, 3'd6,
        3'd0, 3'd6, 3'd6, 3'd6, 3'd0
    };

    barrel_sprite_renderer dut (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .posX      (posX),
        .posY      (posY),
        .frameTick (frameTick),
        .gnt       (gnt),
        .req       (req),
        .vgaPlot   (vgaPlot),
        .vgaXo     (vgaXo),
        .vgaYo     (vgaYo),
        .vgaColour (vgaColour),
        .busy      (busy),
        .done      (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic do_reset;
        @(posedge Clk); #1;
        ResetN    = 1'b0;
        frameTick = 1'b0;
        @(posedge Clk); #1;
        ResetN    = 1'b1;
    endtask

    task automatic start_tick;
        @(posedge Clk); #1;
        frameTick = 1'b1;
        gnt       = 1'b1;
    endtask

    // Cycle 1 is the cycle right after the edge that samples the tick.
    task automatic run_frame(input int budget, output int done_cyc);
        px.delete(); py.delete(); pc.delete();
        done_cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge Clk); #1;
            frameTick = 1'b0;
            gnt = gnt_toggle ? ((c % 2) == 1) : 1'b1;
            @(negedge Clk);
            if (vgaPlot) begin
                px.push_back(vgaXo);
                py.push_back(vgaYo);
                pc.push_back(vgaColour);
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        gnt = 1'b1;
    endtask

    task automatic test_reset;
        posX = 8'd0; posY = 7'd0; gnt = 1'b1;
        do_reset();
        @(negedge Clk);
        vectors++;
        if ({req, vgaPlot, vgaXo, vgaYo, vgaColour, busy, done} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {req, vgaPlot, vgaXo, vgaYo, vgaColour, busy, done});
        end
    endtask

    task automatic test_first_frame;
        int dc;
        posX = 8'd10; posY = 7'd20;
        start_tick();
        run_frame(60, dc);
        vectors++;
        if (dc !== 26) begin
            miscompares++;
            $display("FAIL t1_done_cycle: got %0d expected 26", dc);
        end
        vectors++;
        if ({busy, req} !== 2'b10) begin
            miscompares++;
            $display("FAIL t1_busy_req_at_done: got %b expected 10", {busy, req});
        end
        vectors++;
        if (px.size() !== 25) begin
            miscompares++;
            $display("FAIL t1_plot_count: got %0d expected 25", px.size());
        end
        for (int i = 0; i < 25 && i < px.size(); i++) begin
            vectors++;
            if (px[i] !== 8'(10 + i % 5) || py[i] !== 7'(20 + i / 5) || pc[i] !== spr[i]) begin
                miscompares++;
                $display("FAIL t1_pixel[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                         i, px[i], py[i], pc[i], 10 + i % 5, 20 + i / 5, spr[i]);
            end
        end
        @(posedge Clk); #1;
        @(negedge Clk);
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL t1_idle_after_done: got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_move;
        int dc;
        posX = 8'd11; posY = 7'd20;
        start_tick();
        run_frame(120, dc);
        vectors++;
        if (dc !== 51) begin
            miscompares++;
            $display("FAIL t2_done_cycle: got %0d expected 51", dc);
        end
        vectors++;
        if (px.size() !== 50) begin
            miscompares++;
            $display("FAIL t2_plot_count: got %0d expected 50", px.size());
        end
        for (int i = 0; i < 25 && i < px.size(); i++) begin
            vectors++;
            if (px[i] !== 8'(10 + i % 5) || py[i] !== 7'(20 + i / 5) || pc[i] !== 3'd0) begin
                miscompares++;
                $display("FAIL t2_erase[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,0)",
                         i, px[i], py[i], pc[i], 10 + i % 5, 20 + i / 5);
            end
        end
        for (int i = 0; i < 25 && (i + 25) < px.size(); i++) begin
            vectors++;
            if (px[i+25] !== 8'(11 + i % 5) || py[i+25] !== 7'(20 + i / 5) || pc[i+25] !== spr[i]) begin
                miscompares++;
                $display("FAIL t2_draw[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                         i, px[i+25], py[i+25], pc[i+25], 11 + i % 5, 20 + i / 5, spr[i]);
            end
        end
    endtask

    task automatic test_unchanged;
        int dc;
        start_tick();
        run_frame(10, dc);
        vectors++;
        if (dc !== 1) begin
            miscompares++;
            $display("FAIL t3_done_cycle: got %0d expected 1", dc);
        end
        vectors++;
        if (px.size() !== 0) begin
            miscompares++;
            $display("FAIL t3_plot_count: got %0d expected 0", px.size());
        end
    endtask

    task automatic test_clip;
        int dc;
        logic [7:0] ex [6] = '{8'd157, 8'd158, 8'd159, 8'd157, 8'd158, 8'd159};
        logic [6:0] ey [6] = '{7'd118, 7'd118, 7'd118, 7'd119, 7'd119, 7'd119};
        logic [2:0] ec [6] = '{3'd0, 3'd6, 3'd6, 3'd6, 3'd4, 3'd4};
        do_reset();
        posX = 8'd157; posY = 7'd118;
        start_tick();
        run_frame(60, dc);
        vectors++;
        if (dc !== 26) begin
            miscompares++;
            $display("FAIL t4_done_cycle: got %0d expected 26", dc);
        end
        vectors++;
        if (px.size() !== 6) begin
            miscompares++;
            $display("FAIL t4_plot_count: got %0d expected 6", px.size());
        end
        for (int i = 0; i < 6 && i < px.size(); i++) begin
            vectors++;
            if (px[i] !== ex[i] || py[i] !== ey[i] || pc[i] !== ec[i]) begin
                miscompares++;
                $display("FAIL t4_pixel[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                         i, px[i], py[i], pc[i], ex[i], ey[i], ec[i]);
            end
        end
    endtask

    task automatic test_gnt_stall;
        int dc;
        do_reset();
        posX = 8'd40; posY = 7'd30;
        gnt_toggle = 1'b1;
        start_tick();
        run_frame(120, dc);
        gnt_toggle = 1'b0;
        vectors++;
        if (dc !== 50) begin
            miscompares++;
            $display("FAIL t5_done_cycle: got %0d expected 50", dc);
        end
        vectors++;
        if (px.size() !== 25) begin
            miscompares++;
            $display("FAIL t5_plot_count: got %0d expected 25", px.size());
        end
        for (int i = 0; i < 25 && i < px.size(); i++) begin
            vectors++;
            if (px[i] !== 8'(40 + i % 5) || py[i] !== 7'(30 + i / 5) || pc[i] !== spr[i]) begin
                miscompares++;
                $display("FAIL t5_pixel[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                         i, px[i], py[i], pc[i], 40 + i % 5, 30 + i / 5, spr[i]);
            end
        end
    endtask

    task automatic test_abort;
        int dc;
        // Drawn box is at (40,30) from the previous test; move to (50,30).
        posX = 8'd50; posY = 7'd30;
        start_tick();
        for (int c = 1; c <= 30; c++) begin
            @(posedge Clk); #1;
            frameTick = (c == 5);
            gnt       = 1'b1;
            ResetN    = (c == 30) ? 1'b0 : 1'b1;
            @(negedge Clk);
            if (c == 5) begin
                vectors++;
                if ({vgaPlot, vgaXo, vgaYo, vgaColour} !== {1'b1, 8'd44, 7'd30, 3'd0}) begin
                    miscompares++;
                    $display("FAIL t6_erase_pixel: got (%b,%0d,%0d,%0d) expected (1,44,30,0)",
                             vgaPlot, vgaXo, vgaYo, vgaColour);
                end
            end
            if (c == 28) begin
                vectors++;
                if ({vgaPlot, vgaXo, vgaYo, vgaColour} !== {1'b1, 8'd52, 7'd30, 3'd6}) begin
                    miscompares++;
                    $display("FAIL t6_draw_pixel: got (%b,%0d,%0d,%0d) expected (1,52,30,6)",
                             vgaPlot, vgaXo, vgaYo, vgaColour);
                end
            end
        end
        @(posedge Clk); #1;
        ResetN = 1'b1;
        @(negedge Clk);
        vectors++;
        if ({req, vgaPlot, vgaXo, vgaYo, vgaColour, busy, done} !== 22'd0) begin
            miscompares++;
            $display("FAIL t6_abort_outputs: got %h expected 0",
                     {req, vgaPlot, vgaXo, vgaYo, vgaColour, busy, done});
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            @(negedge Clk);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL t6_pending_cleared[%0d]: got busy=%b expected 0", c, busy);
            end
        end
        start_tick();
        run_frame(60, dc);
        vectors++;
        if (dc !== 26) begin
            miscompares++;
            $display("FAIL t6_redraw_done_cycle: got %0d expected 26", dc);
        end
        vectors++;
        if (px.size() !== 25) begin
            miscompares++;
            $display("FAIL t6_redraw_count: got %0d expected 25", px.size());
        end
        for (int i = 0; i < 25 && i < px.size(); i++) begin
            vectors++;
            if (px[i] !== 8'(50 + i % 5) || py[i] !== 7'(30 + i / 5) || pc[i] !== spr[i]) begin
                miscompares++;
                $display("FAIL t6_redraw[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                         i, px[i], py[i], pc[i], 50 + i % 5, 30 + i / 5, spr[i]);
            end
        end
    endtask

    initial begin
        ResetN    = 1'b0;
        frameTick = 1'b0;
        gnt       = 1'b0;
        posX      = 8'd0;
        posY      = 7'd0;
        repeat (2) @(posedge Clk);
        test_reset();
        test_first_frame();
        test_move();
        test_unchanged();
        test_clip();
        test_gnt_stall();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
